// File: rtl/hazard_pkg.sv
// hazard_pkg: select encodings, writer-entry type and clog2 helper for the hazard unit.
// Entry fields are sized for the widest supported build (REG_W<=8, NUM_FWD<=4).
package hazard_pkg;
    localparam int FWD_SEL_RF    = 0;
    localparam int FWD_SEL_EXMEM = 1;
    localparam int FWD_SEL_MEMWB = 2;
    localparam int MAX_REG_W     = 8;
    localparam int MAX_SEL_W     = 3;

    typedef struct packed {
        logic                 valid;
        logic [MAX_REG_W-1:0] rd;
        logic [MAX_SEL_W-1:0] ready_stage;
    } wr_entry_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: youngest-writer match for one source operand, giving hazard or bypass select.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int REG_W   = 5,
    parameter int SEL_W   = clog2(NUM_FWD + 1)
) (
    input  logic [REG_W-1:0]             i_rs,
    input  logic                         i_used,
    input  wr_entry_t [NUM_FWD-1:0]      i_e,
    output logic                         o_hazard,
    output logic [SEL_W-1:0]             o_sel
);
    logic w_found;

    // Scan from EX outward; the first hit shadows any older writer of the same register.
    always_comb begin
        w_found  = 1'b0;
        o_hazard = 1'b0;
        o_sel    = SEL_W'(FWD_SEL_RF);
        for (int k = 0; k < NUM_FWD; k++) begin
            if (!w_found && i_e[k].valid && i_used && (i_rs != '0) &&
                (i_e[k].rd == MAX_REG_W'(i_rs))) begin
                w_found = 1'b1;
                if (int'(i_e[k].ready_stage) > k) o_hazard = 1'b1;
                else o_sel = SEL_W'(k + 1);
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects and load-use stall with an in-flight writer window.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int REG_W   = 5,
    parameter int SEL_W   = clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [REG_W-1:0]         id_rd,
    input  logic                     id_regwrite,
    input  logic [SEL_W-1:0]         id_ready_stage,
    input  logic                     pipe_hold,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_fwd_cnt
);
    wr_entry_t [NUM_FWD-1:0] r_e;
    logic [NUM_SRC*SEL_W-1:0] r_fwd_sel;
    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic [NUM_SRC-1:0]       w_haz;
    logic                     w_issue;
    wr_entry_t                w_new;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(.NUM_FWD(NUM_FWD), .REG_W(REG_W), .SEL_W(SEL_W)) u_match (
            .i_rs    (id_rs[i*REG_W +: REG_W]),
            .i_used  (id_rs_used[i]),
            .i_e     (r_e),
            .o_hazard(w_haz[i]),
            .o_sel   (w_sel[i*SEL_W +: SEL_W])
        );
    end

    assign stall   = id_valid & ~flush & (|w_haz);
    assign w_issue = id_valid & ~stall & ~flush & ~pipe_hold;
    assign fwd_sel = r_fwd_sel;
    // rd==x0 never creates a producer, so the regfile path stays selected for it.
    assign w_new   = (w_issue && id_regwrite && id_rd != '0) ?
                     '{valid: 1'b1, rd: MAX_REG_W'(id_rd), ready_stage: MAX_SEL_W'(id_ready_stage)} :
                     '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e       <= '0;
            r_fwd_sel <= '0;
        end else if (!pipe_hold) begin
            r_e[0]    <= w_new;
            for (int k = 1; k < NUM_FWD; k++) r_e[k] <= r_e[k-1];
            r_fwd_sel <= w_issue ? w_sel : '0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;
    logic [31:0] w_nz;
    logic [32:0] w_fwd_sum;

    always_comb begin
        w_nz = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (w_sel[i*SEL_W +: SEL_W] != '0) w_nz = w_nz + 32'd1;
    end

    assign w_fwd_sum = {1'b0, r_fwd_cnt} + {1'b0, w_nz};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (!pipe_hold) begin
            if (stall && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_issue) r_fwd_cnt <= w_fwd_sum[32] ? 32'hFFFF_FFFF : w_fwd_sum[31:0];
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_fwd_cnt   = r_fwd_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_fwd_cnt   = '0;
`endif
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised successor of the pipeline forwarding logic: a forwarding-plus-hazard unit with an internal in-flight writer shift register.
- Supports NUM_SRC source operands, NUM_FWD bypass sources, and per-instruction result-ready stage, so loads and multi-stage ops are covered.
- Evaluates the instruction in ID and raises a load-use stall when a needed result is not yet available.
- Registers the forward selects so they are valid while the consumer is in EX.
- Sits between decode and the EX operand muxes.

Parameters:
NUM_SRC, 2, source operands per instruction (1..3)
NUM_FWD, 2, bypass sources after EX: 1=EX/MEM, 2=MEM/WB, ... (1..4)
REG_W, 5, register address width
SEL_W, $clog2(NUM_FWD+1), width of one forward select and of a ready-stage field (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  valid instruction in ID
id_rs  in  NUM_SRC*REG_W  source register addresses (src i at [i*REG_W +: REG_W])
id_rs_used  in  NUM_SRC  source i is actually read
id_rd  in  REG_W  destination register
id_regwrite  in  1  instruction writes id_rd
id_ready_stage  in  SEL_W  stage after which the result is forwardable (0=EX, 1=MEM, ...)
pipe_hold  in  1  global freeze (e.g. memory wait)
flush  in  1  kill the instruction in ID (branch redirect)
stall  out  1  hold IF/ID, insert bubble into EX (combinational)
fwd_sel  out  NUM_SRC*SEL_W  registered select per source: 0=regfile, j=bypass source j
perf_stall_cnt  out  32  stall-cycle counter (optional feature)
perf_fwd_cnt  out  32  forwarded-operand counter (optional feature)

Behaviour:
- Clock, reset and polarity: one clock, clk. Reset rst_n is asynchronous and active-low.
- On reset: all entries invalid, fwd_sel=0, stall=0, counters=0.
- Writer pipeline: entries e[0..NUM_FWD-1], each holding {valid, rd, ready_stage}. e[k] is the producer currently in stage k (e[0]=EX).
- Issue condition: issue = id_valid & ~stall & ~flush & ~pipe_hold.
- Each clock edge with ~pipe_hold:
  - e[0] <= issue & id_regwrite & (id_rd!=0) ? {1, id_rd, id_ready_stage} : invalid.
  - e[k] <= e[k-1].
  - e[NUM_FWD-1] is dropped; the regfile is write-before-read.
- Matching per source i:
  - Consider only entries with valid & rd==id_rs[i] & id_rs_used[i] & id_rs[i]!=0.
  - The youngest match (smallest k) wins.
  - If its ready_stage > k, it is a hazard; older matches are ignored.
  - Otherwise the next select for source i is k+1.
  - With no match, the next select is 0.
- stall = id_valid & ~flush & OR of hazards over all sources. Combinational; no registered latency.
- fwd_sel update, when ~pipe_hold:
  - On issue: loaded with the computed selects.
  - Otherwise: cleared to 0 (bubble in EX).
- Latency: a select is visible exactly one cycle after the ID-cycle evaluation.
- A ready_stage >= NUM_FWD is never forwardable. The consumer stalls until the writer leaves the window, then reads the regfile.
- pipe_hold has priority: entries, fwd_sel and counters are all held, and flush is ignored that cycle. stall is still computed from held state.
- flush with ~pipe_hold: no issue, bubble into e[0], fwd_sel cleared, stall=0.
- rst_n asserted mid-stall: all state clears immediately, without waiting for the clock.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: perf_stall_cnt increments on every cycle with stall & ~pipe_hold. perf_fwd_cnt increments by the number of nonzero selects loaded on issue. Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package hazard_pkg holds:
  - select encoding constants (FWD_SEL_RF=0, FWD_SEL_EXMEM=1, FWD_SEL_MEMWB=2)
  - the writer-entry struct {valid, rd, ready_stage}
  - a clog2 helper
- Sub-module hazard_src_match is purely combinational and instantiated NUM_SRC times.
  - Inputs: one source address, used bit, flattened entries.
  - Outputs: hazard and select.
- Sequential state lives in the top level.

Test Plan:
1. ALU chain: issue add x5 (ready 0), then sub with rs1=x5 -> stall=0; next cycle fwd_sel[src0]=1.
2. Load-use: lw x6 (ready 1), then add with rs2=x6 -> stall=1 for exactly 1 cycle with a bubble; at issue fwd_sel[src1]=2.
3. Priority: writers to x7 at e[0] (ready 0) and e[1], consumer rs1=x7 -> sel 1. Same with e[0] ready 1 -> stall even though e[1] is ready.
4. Zero/unused: writer with rd=x0 and consumer rs1=x0 -> sel 0, no stall. Matching load with id_rs_used=0 -> no stall, sel 0.
5. Hold: load-use stall, then pipe_hold=1 for 3 cycles -> stall stays 1, fwd_sel and entries frozen. Release -> one stall cycle, then issue with sel 2. flush during hold is ignored.
6. Reset: assert rst_n=0 mid-stall between edges -> stall=0 and fwd_sel=0 immediately. With HAZARD_PERF_CNT_EN, scenario 2 yields perf_stall_cnt=1 and perf_fwd_cnt=1.
